nx_indirect_access_mem_port: RTL and testbench

- Memory-side responder for the indirect-access software port.
- Holds an N_ENTRIES x N_DATA_BITS flop-array table shared by two requesters:
  - the hardware datapath;
  - the indirect-access controller, which drives sw_cs/sw_ce/sw_we/sw_add/sw_wdat/yield/reset.
- Arbitrates between them with starvation protection and returns grant.
- Returns read data and compare (match/index) results at the fixed latencies the controller's READ_DONE/COMPARE_DONE states sample.

---
 rtl/nx_indirect_access_mem_port_pkg.sv | 10 +
 rtl/nx_indirect_access_mem_port_cmp_match.sv | 61 ++++++
 rtl/nx_indirect_access_mem_port.sv | 129 ++++++++++++
 tb/tb_nx_indirect_access_mem_port.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nx_indirect_access_mem_port_pkg.sv
// Shared types and default sizing for the indirect-access memory port.
package nx_indirect_access_mem_port_pkg;

  localparam int IA_N_CMP_ENTRIES = 16;
  localparam int IA_STARVE_LIMIT  = 4;
  localparam int STARVE_W         = $clog2(IA_STARVE_LIMIT + 1);

  typedef logic [IA_N_CMP_ENTRIES-1:0] ia_cmp_vec_t;

endpackage

// File: rtl/nx_indirect_access_mem_port_cmp_match.sv
// Parallel key compare over the low table entries, with a registered hit vector
// followed by a registered lowest-index priority encode.
module nx_ia_cmp_match
  import nx_indirect_access_mem_port_pkg::*;
#(
  parameter int N_CMP_ENTRIES = IA_N_CMP_ENTRIES,
  parameter int N_DATA_BITS   = 32,
  parameter int N_AINDEX_BITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cmp_en,
  input  logic [N_DATA_BITS-1:0]               cmp_key,
  input  logic [N_CMP_ENTRIES*N_DATA_BITS-1:0] cmp_entries,
  output logic                                 cmp_match,
  output logic [N_AINDEX_BITS-1:0]             cmp_aindex
);

  logic [N_CMP_ENTRIES-1:0] hit;
  logic [N_CMP_ENTRIES-1:0] vec_d, vec_q;
  logic                     pend_d, pend_q;
  logic                     match_d, match_q;
  logic [N_AINDEX_BITS-1:0] aindex_d, aindex_q, enc;

  for (genvar gi = 0; gi < N_CMP_ENTRIES; gi++) begin : g_hit
    assign hit[gi] = (cmp_entries[gi*N_DATA_BITS +: N_DATA_BITS] == cmp_key);
  end

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    enc = '0;
    for (int i = N_CMP_ENTRIES - 1; i >= 0; i--) begin
      if (vec_q[i]) enc = N_AINDEX_BITS'(i);
    end
  end

  always_comb begin
    vec_d    = cmp_en ? hit : vec_q;
    pend_d   = cmp_en;
    match_d  = pend_q ? (|vec_q) : match_q;
    aindex_d = pend_q ? enc : aindex_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      pend_q   <= 1'b0;
      match_q  <= 1'b0;
      aindex_q <= '0;
    end else begin
      vec_q    <= vec_d;
      pend_q   <= pend_d;
      match_q  <= match_d;
      aindex_q <= aindex_d;
    end
  end

  assign cmp_match  = match_q;
  assign cmp_aindex = aindex_q;

endmodule

// File: rtl/nx_indirect_access_mem_port.sv
// Table shared by the hardware datapath and the indirect-access controller,
// with starvation-protected arbitration, registered reads and a two-stage compare.
module nx_indirect_access_mem_port
  import nx_indirect_access_mem_port_pkg::*;
#(
  parameter int                     N_ENTRIES     = 32,
  parameter int                     N_DATA_BITS   = 32,
  parameter int                     N_CMP_ENTRIES = IA_N_CMP_ENTRIES,
  parameter int                     N_AINDEX_BITS = 4,
  parameter int                     STARVE_LIMIT  = IA_STARVE_LIMIT,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA    = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sw_cs,
  input  logic                     sw_ce,
  input  logic                     sw_we,
  input  logic [4:0]               sw_add,
  input  logic [N_DATA_BITS-1:0]   sw_wdat,
  input  logic                     yield,
  input  logic                     reset,
  output logic                     grant,
  output logic [N_DATA_BITS-1:0]   sw_rdat,
  output logic                     sw_match,
  output logic [N_AINDEX_BITS-1:0] sw_aindex,
  input  logic                     hw_rd,
  input  logic                     hw_wr,
  input  logic [4:0]               hw_add,
  input  logic [N_DATA_BITS-1:0]   hw_wdat,
  output logic [N_DATA_BITS-1:0]   hw_rdat,
  output logic                     hw_stall,
  output logic [7:0]               rst_wr_cnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [N_DATA_BITS-1:0] entry_d [N_ENTRIES];
  logic [N_DATA_BITS-1:0] entry_q [N_ENTRIES];

  logic [CNT_W-1:0]       starve_d, starve_q;
  logic [N_DATA_BITS-1:0] sw_rdat_d, sw_rdat_q;
  logic [N_DATA_BITS-1:0] hw_rdat_d, hw_rdat_q;
  logic [7:0]             rst_wr_cnt_d, rst_wr_cnt_q;

  logic hw_req, hw_go;
  logic sw_wr_en, sw_rd_en, sw_cmp_en, hw_wr_en, hw_rd_en;
  logic [N_DATA_BITS-1:0] sw_mux, hw_mux;
  logic [N_CMP_ENTRIES*N_DATA_BITS-1:0] cmp_entries;

  assign hw_req    = hw_rd | hw_wr;
  assign grant     = sw_cs && (!hw_req || yield || (starve_q >= CNT_W'(STARVE_LIMIT)));
  assign hw_stall  = hw_req && grant;
  assign hw_go     = hw_req && !grant;

  assign sw_wr_en  = grant && sw_we;
  assign sw_cmp_en = grant && sw_ce && !sw_we;
  assign sw_rd_en  = grant && !sw_we && !sw_ce;
  // A simultaneous read+write from the datapath is a write only.
  assign hw_wr_en  = hw_go && hw_wr;
  assign hw_rd_en  = hw_go && hw_rd && !hw_wr;

  // Address decode by loop: out-of-range addresses match nothing, so writes
  // drop and reads return zero.
  always_comb begin
    sw_mux = '0;
    hw_mux = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      entry_d[i] = entry_q[i];
      if (sw_wr_en && (sw_add == 5'(i))) entry_d[i] = sw_wdat;
      if (hw_wr_en && (hw_add == 5'(i))) entry_d[i] = hw_wdat;
      if (sw_add == 5'(i)) sw_mux = entry_q[i];
      if (hw_add == 5'(i)) hw_mux = entry_q[i];
    end
  end

  always_comb begin
    starve_d     = starve_q;
    sw_rdat_d    = sw_rdat_q;
    hw_rdat_d    = hw_rdat_q;
    rst_wr_cnt_d = rst_wr_cnt_q;
    if (!sw_cs || grant) begin
      starve_d = '0;
    end else if (starve_q < CNT_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + 1'b1;
    end
    if (sw_rd_en) sw_rdat_d = sw_mux;
    if (hw_rd_en) hw_rdat_d = hw_mux;
    if (sw_wr_en && reset && (rst_wr_cnt_q != 8'hFF)) rst_wr_cnt_d = rst_wr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= RESET_DATA;
      starve_q     <= '0;
      sw_rdat_q    <= '0;
      hw_rdat_q    <= '0;
      rst_wr_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) entry_q[i] <= entry_d[i];
      starve_q     <= starve_d;
      sw_rdat_q    <= sw_rdat_d;
      hw_rdat_q    <= hw_rdat_d;
      rst_wr_cnt_q <= rst_wr_cnt_d;
    end
  end

  for (genvar gi = 0; gi < N_CMP_ENTRIES; gi++) begin : g_cmp_flat
    assign cmp_entries[gi*N_DATA_BITS +: N_DATA_BITS] = entry_q[gi];
  end

  nx_ia_cmp_match #(
    .N_CMP_ENTRIES (N_CMP_ENTRIES),
    .N_DATA_BITS   (N_DATA_BITS),
    .N_AINDEX_BITS (N_AINDEX_BITS)
  ) u_cmp (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmp_en      (sw_cmp_en),
    .cmp_key     (sw_wdat),
    .cmp_entries (cmp_entries),
    .cmp_match   (sw_match),
    .cmp_aindex  (sw_aindex)
  );

  assign sw_rdat    = sw_rdat_q;
  assign hw_rdat    = hw_rdat_q;
  assign rst_wr_cnt = rst_wr_cnt_q;

endmodule

// File: tb/tb_nx_indirect_access_mem_port.sv
module tb_nx_indirect_access_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_cs, sw_ce, sw_we, yield, reset;
    logic [4:0]  sw_add, hw_add;
    logic [31:0] sw_wdat, hw_wdat;
    logic        grant, sw_match, hw_stall, hw_rd, hw_wr;
    logic [31:0] sw_rdat, hw_rdat;
    logic [3:0]  sw_aindex;
    logic [7:0]  rst_wr_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nx_indirect_access_mem_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_cs      (sw_cs),
        .sw_ce      (sw_ce),
        .sw_we      (sw_we),
        .sw_add     (sw_add),
        .sw_wdat    (sw_wdat),
        .yield      (yield),
        .reset      (reset),
        .grant      (grant),
        .sw_rdat    (sw_rdat),
        .sw_match   (sw_match),
        .sw_aindex  (sw_aindex),
        .hw_rd      (hw_rd),
        .hw_wr      (hw_wr),
        .hw_add     (hw_add),
        .hw_wdat    (hw_wdat),
        .hw_rdat    (hw_rdat),
        .hw_stall   (hw_stall),
        .rst_wr_cnt (rst_wr_cnt)
    );

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("PASS %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sw_cs = 0; sw_ce = 0; sw_we = 0; sw_add = '0; sw_wdat = '0;
        yield = 0; reset = 0; hw_rd = 0; hw_wr = 0; hw_add = '0; hw_wdat = '0;
    endtask

    task automatic sw_write(input logic [4:0] a, input logic [31:0] d);
        sw_cs = 1; sw_we = 1; sw_ce = 0; sw_add = a; sw_wdat = d;
        tick();
        sw_cs = 0; sw_we = 0;
    endtask

    task automatic sw_read_chk(input logic [4:0] a, input logic [31:0] exp, input string tag);
        sw_cs = 1; sw_we = 0; sw_ce = 0; sw_add = a;
        @(negedge clk);
        chk({tag, "_grant"}, grant === 1'b1, grant, 1'b1);
        tick();
        sw_cs = 0;
        chk(tag, sw_rdat === exp, sw_rdat, exp);
    endtask

    initial begin
        idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", grant === 1'b0, grant, 1'b0);
        chk("rst_hw_stall", hw_stall === 1'b0, hw_stall, 1'b0);
        chk("rst_sw_rdat", sw_rdat === 32'h0, sw_rdat, 32'h0);
        chk("rst_sw_match", sw_match === 1'b0, sw_match, 1'b0);
        chk("rst_sw_aindex", sw_aindex === 4'h0, sw_aindex, 4'h0);
        chk("rst_hw_rdat", hw_rdat === 32'h0, hw_rdat, 32'h0);
        chk("rst_wr_cnt", rst_wr_cnt === 8'h0, rst_wr_cnt, 8'h0);
        rst_n = 1;
        tick();

        sw_cs = 1; sw_we = 1; sw_add = 5; sw_wdat = 32'hA5A5_0001;
        @(negedge clk);
        chk("wr5_grant", grant === 1'b1, grant, 1'b1);
        tick();
        sw_cs = 0; sw_we = 0;
        sw_read_chk(5, 32'hA5A5_0001, "rd5");

        sw_write(3, 32'hDEAD_BEEF);
        sw_write(9, 32'hDEAD_BEEF);
        sw_cs = 1; sw_ce = 1; sw_we = 0; sw_wdat = 32'hDEAD_BEEF;
        tick();
        sw_cs = 0; sw_ce = 0;
        chk("cmp_hit_t1_match", sw_match === 1'b0, sw_match, 1'b0);
        tick();
        chk("cmp_hit_match", sw_match === 1'b1, sw_match, 1'b1);
        chk("cmp_hit_aindex", sw_aindex === 4'd3, sw_aindex, 4'd3);
        tick();
        chk("cmp_hit_held", sw_aindex === 4'd3, sw_aindex, 4'd3);
        sw_cs = 1; sw_ce = 1; sw_wdat = 32'h0000_1234;
        tick();
        sw_cs = 0; sw_ce = 0;
        tick();
        chk("cmp_miss_match", sw_match === 1'b0, sw_match, 1'b0);
        chk("cmp_miss_aindex", sw_aindex === 4'd0, sw_aindex, 4'd0);

        hw_rd = 1; hw_add = 3; sw_cs = 1; sw_we = 0; sw_add = 5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk($sformatf("starve_c%0d_grant", c), grant === 1'b0, grant, 1'b0);
            chk($sformatf("starve_c%0d_stall", c), hw_stall === 1'b0, hw_stall, 1'b0);
            tick();
        end
        chk("starve_hw_rdat", hw_rdat === 32'hDEAD_BEEF, hw_rdat, 32'hDEAD_BEEF);
        hw_add = 5;
        @(negedge clk);
        chk("starve_c5_grant", grant === 1'b1, grant, 1'b1);
        chk("starve_c5_stall", hw_stall === 1'b1, hw_stall, 1'b1);
        tick();
        chk("starve_c5_hw_rdat_held", hw_rdat === 32'hDEAD_BEEF, hw_rdat, 32'hDEAD_BEEF);
        chk("starve_c5_sw_rdat", sw_rdat === 32'hA5A5_0001, sw_rdat, 32'hA5A5_0001);
        @(negedge clk);
        chk("starve_c6_cleared", grant === 1'b0, grant, 1'b0);
        tick();
        chk("starve_c6_hw_rdat", hw_rdat === 32'hA5A5_0001, hw_rdat, 32'hA5A5_0001);
        idle();

        hw_wr = 1; hw_add = 10; hw_wdat = 32'h100;
        sw_cs = 1; sw_we = 1; sw_add = 11; sw_wdat = 32'h11;
        @(negedge clk);
        chk("yield_c1_grant", grant === 1'b0, grant, 1'b0);
        tick();
        hw_add = 12; hw_wdat = 32'h200; yield = 1;
        @(negedge clk);
        chk("yield_c2_grant", grant === 1'b1, grant, 1'b1);
        chk("yield_c2_stall", hw_stall === 1'b1, hw_stall, 1'b1);
        tick();
        hw_add = 13; hw_wdat = 32'h300; yield = 0;
        @(negedge clk);
        chk("yield_c3_grant", grant === 1'b0, grant, 1'b0);
        chk("yield_c3_stall", hw_stall === 1'b0, hw_stall, 1'b0);
        tick();
        idle();
        sw_read_chk(10, 32'h100, "yield_e10");
        sw_read_chk(11, 32'h11, "yield_e11");
        sw_read_chk(12, 32'h0, "yield_e12");
        sw_read_chk(13, 32'h300, "yield_e13");

        sw_write(14, 32'h77);
        chk("plain_wr_cnt", rst_wr_cnt === 8'd0, rst_wr_cnt, 8'd0);
        reset = 1;
        for (int a = 0; a < 20; a++) sw_write(5'(a), 32'hF0 + 32'(a));
        chk("sweep_cnt", rst_wr_cnt === 8'd20, rst_wr_cnt, 8'd20);
        sw_read_chk(19, 32'h103, "sweep_e19");
        reset = 1; sw_cs = 1; sw_we = 1; sw_add = 20; sw_wdat = 32'hBAD0;
        #1;
        rst_n = 0;
        #1;
        chk("arst_cnt", rst_wr_cnt === 8'd0, rst_wr_cnt, 8'd0);
        chk("arst_sw_rdat", sw_rdat === 32'h0, sw_rdat, 32'h0);
        sw_cs = 0; sw_we = 0; reset = 0;
        @(negedge clk);
        chk("arst_grant", grant === 1'b0, grant, 1'b0);
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_grant", grant === 1'b0, grant, 1'b0);
        sw_read_chk(20, 32'h0, "post_rst_e20");
        sw_read_chk(5, 32'h0, "post_rst_e5");
        sw_read_chk(3, 32'h0, "post_rst_e3");

        sw_write(7, 32'h99);
        hw_rd = 1; hw_add = 7;
        tick();
        chk("hw_rd7", hw_rdat === 32'h99, hw_rdat, 32'h99);
        hw_wr = 1; hw_wdat = 32'h55;
        tick();
        chk("hw_rdwr_rdat_held", hw_rdat === 32'h99, hw_rdat, 32'h99);
        hw_wr = 0;
        tick();
        chk("hw_rd7_new", hw_rdat === 32'h55, hw_rdat, 32'h55);
        idle();
        sw_read_chk(7, 32'h55, "sw_rd7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
